// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   640x480@60 Hz VGA raster timing generated from the 50 MHz system clock.
//   A Clk-rate enable (pix_en) toggles every Clk, so the pixel counters
//   advance at 25 MHz. The module publishes the current raster position
//   (DrawX/DrawY) to the renderers and takes their combinational colour
//   answer back (Red_in/Green_in/Blue_in). That colour is blanked outside
//   the visible window and forwarded, together with the syncs, to the
//   ADV7123 DAC pins.
//
// Renderer contract:
//   There is no valid/ready pair. Every Clk the renderer must present the
//   colour for the DrawX/DrawY currently on the outputs, combinationally.
//   The coordinates are not clamped during blanking, so the renderer must
//   tolerate DrawX up to H_TOTAL-1 and DrawY up to V_TOTAL-1.
//
// Configuration macro:
//   VGA_RGB_REG_EN - when defined, VGA_R/G/B, VGA_HS, VGA_VS and
//   VGA_BLANK_N pass through one output register loaded on pix_en cycles.
//   DAC outputs then lag DrawX/DrawY by exactly one pixel (2 Clk), and
//   syncs stay aligned with colour. When undefined the DAC outputs are
//   decoded combinationally from the counters.
//
// Ports:
//   Clk          in   50 MHz system clock
//   Reset        in   synchronous, active-high
//   Red_in       in 8 renderer red for current DrawX/DrawY
//   Green_in     in 8 renderer green
//   Blue_in      in 8 renderer blue
//   DrawX        out10 horizontal counter, 0..H_TOTAL-1
//   DrawY        out10 vertical counter, 0..V_TOTAL-1
//   pix_en       out  Clk-rate enable, high every other Clk
//   VGA_CLK      out  25 MHz pixel clock to DAC (same register as pix_en)
//   VGA_HS       out  horizontal sync, active-low
//   VGA_VS       out  vertical sync, active-low
//   VGA_BLANK_N  out  high inside the visible window
//   VGA_SYNC_N   out  constant 0 (sync-on-green unused)
//   VGA_R/G/B    out8 DAC colour
//   frame_start  out  one-Clk pulse on the Clk whose edge wraps to (0,0)
//   o_h_phase    out2 debug: horizontal phase (0 ACTIVE,1 FRONT,2 SYNC,3 BACK)
//   o_v_phase    out2 debug: vertical phase, same encoding
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pix_en,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start,
  output logic [1:0] o_h_phase,
  output logic [1:0] o_v_phase
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Phase boundaries as 10-bit constants so every counter compare is
  // width-matched.
  localparam logic [9:0] H_ACT_END  = 10'(H_VISIBLE);
  localparam logic [9:0] H_FP_END   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_VISIBLE);
  localparam logic [9:0] V_FP_END   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  // The raster "state" of each axis is implied by the counter range; this
  // enum only names those ranges for the decode and the debug outputs.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  logic       r_pix_en;
  logic [9:0] r_hc;
  logic [9:0] r_vc;

  logic       w_h_last;
  logic       w_v_last;
  phase_t     w_h_phase;
  phase_t     w_v_phase;
  logic       w_hs_n;
  logic       w_vs_n;
  logic       w_blank_n;
  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;

  assign w_h_last = (r_hc == H_LAST);
  assign w_v_last = (r_vc == V_LAST);

  // -------------------------------------------------------------------------
  // Pixel enable and raster counters. hc moves only on pix_en edges, so each
  // hc value is held for exactly two Clk. Reset forces pix_en low, which
  // puts the first counter increment on the second edge after release.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pix_en <= 1'b0;
      r_hc     <= 10'd0;
      r_vc     <= 10'd0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (w_h_last) begin
          r_hc <= 10'd0;
          if (w_v_last) begin
            r_vc <= 10'd0;
          end else begin
            r_vc <= r_vc + 10'd1;
          end
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Phase decode per axis.
  // -------------------------------------------------------------------------
  always_comb begin
    w_h_phase = PH_ACTIVE;
    if (r_hc < H_ACT_END) begin
      w_h_phase = PH_ACTIVE;
    end else if (r_hc < H_FP_END) begin
      w_h_phase = PH_FRONT;
    end else if (r_hc < H_SYNC_END) begin
      w_h_phase = PH_SYNC;
    end else begin
      w_h_phase = PH_BACK;
    end
  end

  always_comb begin
    w_v_phase = PH_ACTIVE;
    if (r_vc < V_ACT_END) begin
      w_v_phase = PH_ACTIVE;
    end else if (r_vc < V_FP_END) begin
      w_v_phase = PH_FRONT;
    end else if (r_vc < V_SYNC_END) begin
      w_v_phase = PH_SYNC;
    end else begin
      w_v_phase = PH_BACK;
    end
  end

  assign w_hs_n    = (w_h_phase != PH_SYNC);
  assign w_vs_n    = (w_v_phase != PH_SYNC);
  assign w_blank_n = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

  // Colour gated to black whenever the beam is outside the visible window.
  always_comb begin
    w_r = 8'd0;
    w_g = 8'd0;
    w_b = 8'd0;
    if (w_blank_n) begin
      w_r = Red_in;
      w_g = Green_in;
      w_b = Blue_in;
    end
  end

  // -------------------------------------------------------------------------
  // DAC-side outputs.
  // -------------------------------------------------------------------------
`ifdef VGA_RGB_REG_EN
  logic       r_hs_n;
  logic       r_vs_n;
  logic       r_blank_n;
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;

  // Loaded on the same edge that advances hc, so the registered values
  // belong to the pixel just left: exactly one pixel of lag, with syncs and
  // colour moving together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hs_n    <= 1'b1;
      r_vs_n    <= 1'b1;
      r_blank_n <= 1'b0;
      r_r       <= 8'd0;
      r_g       <= 8'd0;
      r_b       <= 8'd0;
    end else if (r_pix_en) begin
      r_hs_n    <= w_hs_n;
      r_vs_n    <= w_vs_n;
      r_blank_n <= w_blank_n;
      r_r       <= w_r;
      r_g       <= w_g;
      r_b       <= w_b;
    end
  end

  assign VGA_HS      = r_hs_n;
  assign VGA_VS      = r_vs_n;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;
`else
  assign VGA_HS      = w_hs_n;
  assign VGA_VS      = w_vs_n;
  assign VGA_BLANK_N = w_blank_n;
  assign VGA_R       = w_r;
  assign VGA_G       = w_g;
  assign VGA_B       = w_b;
`endif

  assign DrawX      = r_hc;
  assign DrawY      = r_vc;
  assign pix_en     = r_pix_en;
  assign VGA_CLK    = r_pix_en;
  assign VGA_SYNC_N = 1'b0;

  // High during the Clk whose closing edge takes (H_LAST,V_LAST) to (0,0).
  assign frame_start = r_pix_en && w_h_last && w_v_last;

  assign o_h_phase = w_h_phase;
  assign o_v_phase = w_v_phase;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clock, reset and colour inputs: a shrunken raster
// (30x19 totals, 1140 Clk per frame) so several whole frames fit in a short
// run, and the default 800x525 raster for the real line timing. Expected
// values come from a position model: n = Clk edges since the last reset
// edge, pixel = n/2, x = pixel mod H_TOTAL, y = (pixel / H_TOTAL) mod
// V_TOTAL, and every output is derived from x, y with range tests.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Shrunken raster
  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int S_HT = SHV + SHF + SHS + SHB;
  localparam int S_VT = SVV + SVF + SVS + SVB;
  localparam int S_FRAME = 2 * S_HT * S_VT;
  // Default raster
  localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;
  localparam int D_HT = DHV + DHF + DHS + DHB;

  typedef struct {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
    logic [1:0] hp;
    logic [1:0] vp;
  } exp_t;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } pipe_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;

  always #10 clk = ~clk;

  // ---------------- DUT outputs ----------------
  logic [9:0] s_x, s_y, d_x, d_y;
  logic s_pe, s_vclk, s_hs, s_vs, s_bl, s_sn, s_fs;
  logic d_pe, d_vclk, d_hs, d_vs, d_bl, d_sn, d_fs;
  logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;
  logic [1:0] s_hp, s_vp, d_hp, d_vp;

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .Clk(clk), .Reset(rst), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
    .DrawX(s_x), .DrawY(s_y), .pix_en(s_pe), .VGA_CLK(s_vclk),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sn),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .frame_start(s_fs),
    .o_h_phase(s_hp), .o_v_phase(s_vp)
  );

  vga_timing_gen u_dflt (
    .Clk(clk), .Reset(rst), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
    .DrawX(d_x), .DrawY(d_y), .pix_en(d_pe), .VGA_CLK(d_vclk),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bl), .VGA_SYNC_N(d_sn),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .frame_start(d_fs),
    .o_h_phase(d_hp), .o_v_phase(d_vp)
  );

  // ---------------- bookkeeping ----------------
  int          n_vec = 0;
  int          n_err = 0;
  longint      n = 0;       // edges since last reset edge
  int          cyc = 0;     // total edges
  logic        rst_edge = 1'b0;
  logic [31:0] exp_q[$];    // expected frame_start cycles (small raster)
  int          s_hs_run = 0, d_hs_run = 0, s_vs_run = 0;
  pipe_t       ps, pd;

  // ---------------- reference model ----------------
  function automatic exp_t model_at(longint nn, int hv, int hf, int hs, int hb,
                                    int vv, int vf, int vs, int vb);
    exp_t   e;
    longint k;
    int     ht, vt, x, y;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    k  = nn / 2;
    x  = int'(k % ht);
    y  = int'((k / ht) % vt);
    e.pe = ((nn % 2) == 1);
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.hs = !((x >= hv + hf) && (x < hv + hf + hs));
    e.vs = !((y >= vv + vf) && (y < vv + vf + vs));
    e.bl = (x < hv) && (y < vv);
    e.fs = e.pe && (x == ht - 1) && (y == vt - 1);
    e.hp = (x < hv) ? 2'd0 : (x < hv + hf) ? 2'd1 : (x < hv + hf + hs) ? 2'd2 : 2'd3;
    e.vp = (y < vv) ? 2'd0 : (y < vv + vf) ? 2'd1 : (y < vv + vf + vs) ? 2'd2 : 2'd3;
    return e;
  endfunction

  function automatic exp_t model_s(longint nn);
    return model_at(nn, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  function automatic exp_t model_d(longint nn);
    return model_at(nn, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB);
  endfunction

  function automatic pipe_t pipe_reset();
    pipe_t p;
    p.hs = 1'b1; p.vs = 1'b1; p.bl = 1'b0; p.rgb = 24'd0;
    return p;
  endfunction

  function automatic pipe_t pipe_load(exp_t e, logic [23:0] rgb_in);
    pipe_t p;
    p.hs = e.hs; p.vs = e.vs; p.bl = e.bl;
    p.rgb = e.bl ? rgb_in : 24'd0;
    return p;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic check_inst(input string p, input exp_t e, input pipe_t pp,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic pe, input logic vclk, input logic hs,
                            input logic vs, input logic bl, input logic sn,
                            input logic fs, input logic [23:0] rgb,
                            input logic [1:0] hp, input logic [1:0] vp);
    logic        w_hs, w_vs, w_bl;
    logic [23:0] w_rgb;
`ifdef VGA_RGB_REG_EN
    w_hs = pp.hs; w_vs = pp.vs; w_bl = pp.bl; w_rgb = pp.rgb;
`else
    w_hs = e.hs; w_vs = e.vs; w_bl = e.bl;
    w_rgb = e.bl ? {r_in, g_in, b_in} : 24'd0;
`endif
    check_eq({p, ".drawx"},   32'(x),    32'(e.x));
    check_eq({p, ".drawy"},   32'(y),    32'(e.y));
    check_eq({p, ".pix_en"},  32'(pe),   32'(e.pe));
    check_eq({p, ".vga_clk"}, 32'(vclk), 32'(e.pe));
    check_eq({p, ".hs"},      32'(hs),   32'(w_hs));
    check_eq({p, ".vs"},      32'(vs),   32'(w_vs));
    check_eq({p, ".blank_n"}, 32'(bl),   32'(w_bl));
    check_eq({p, ".sync_n"},  32'(sn),   32'd0);
    check_eq({p, ".rgb"},     32'(rgb),  32'(w_rgb));
    check_eq({p, ".fs"},      32'(fs),   32'(e.fs));
    check_eq({p, ".hphase"},  32'(hp),   32'(e.hp));
    check_eq({p, ".vphase"},  32'(vp),   32'(e.vp));
  endtask

  // Length of each complete active-low run; runs cut by reset are dropped.
  task automatic track_run(input string tag, input logic lvl, input int want, inout int run);
    if (rst_edge) begin
      run = 0;
    end else if (!lvl) begin
      run++;
    end else if (run > 0) begin
      check_eq(tag, 32'(run), 32'(want));
      run = 0;
    end
  endtask

  // ---------------- driver: one Clk ----------------
  task automatic cycle();
    exp_t eo_s, eo_d;
    @(posedge clk);
    eo_s = model_s(n);
    eo_d = model_d(n);
    if (rst) begin
      ps = pipe_reset();
      pd = pipe_reset();
    end else if (eo_s.pe) begin
      ps = pipe_load(eo_s, {r_in, g_in, b_in});
      pd = pipe_load(eo_d, {r_in, g_in, b_in});
    end
    n = rst ? 0 : n + 1;
    rst_edge = rst;
    cyc++;
    @(negedge clk);
    check_inst("s", model_s(n), ps, s_x, s_y, s_pe, s_vclk, s_hs, s_vs, s_bl,
               s_sn, s_fs, {s_r, s_g, s_b}, s_hp, s_vp);
    check_inst("d", model_d(n), pd, d_x, d_y, d_pe, d_vclk, d_hs, d_vs, d_bl,
               d_sn, d_fs, {d_r, d_g, d_b}, d_hp, d_vp);
    track_run("s.hs_low_len", s_hs, 2 * SHS, s_hs_run);
    track_run("d.hs_low_len", d_hs, 2 * DHS, d_hs_run);
    track_run("s.vs_low_len", s_vs, 2 * S_HT * SVS, s_vs_run);
    // frame_start scoreboard for the small raster
    if (rst_edge) begin
      exp_q.delete();
      exp_q.push_back(32'(cyc + S_FRAME - 1));
    end else begin
      if (exp_q.size() > 0 && exp_q[0] < 32'(cyc)) begin
        check_eq("s.fs_missed", 32'(cyc), exp_q.pop_front());
      end
      if (s_fs) begin
        if (exp_q.size() == 0) begin
          check_eq("s.fs_unexpected", 32'(s_fs), 32'd0);
        end else begin
          check_eq("s.fs_time", 32'(cyc), exp_q.pop_front());
        end
        exp_q.push_back(32'(cyc + S_FRAME));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int   x_tbl[4]  = '{0, 1, 1, 2};
  logic pe_tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    exp_t e;
    logic hit;
    ps = pipe_reset();
    pd = pipe_reset();

    // Reset held for 3 Clk.
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    r_in = 8'h6f; g_in = 8'h39; b_in = 8'h9d;

    // Fixed colour phase: start-up sequence and blanking points.
    for (int i = 0; i < 5000; i++) begin
      cycle();
      if (i < 4) begin
        check_eq("start.drawx", 32'(s_x), 32'(x_tbl[i]));
        check_eq("start.pix_en", 32'(s_pe), 32'(pe_tbl[i]));
      end
`ifndef VGA_RGB_REG_EN
      e = model_s(n);
      if (e.x == 10'd5 && e.y == 10'd5)
        check_eq("s.rgb_visible", 32'({s_r, s_g, s_b}), 32'h6f399d);
      if (e.x == 10'd18 && e.y == 10'd5)
        check_eq("s.rgb_hblank", 32'({s_r, s_g, s_b}), 32'h0);
      if (e.x == 10'd5 && e.y == 10'd15)
        check_eq("s.rgb_vblank", 32'({s_r, s_g, s_b}), 32'h0);
      e = model_d(n);
      if (e.x == 10'd100 && e.y == 10'd2)
        check_eq("d.rgb_visible", 32'({d_r, d_g, d_b}), 32'h6f399d);
      if (e.x == 10'd700 && e.y == 10'd2)
        check_eq("d.rgb_hblank", 32'({d_r, d_g, d_b}), 32'h0);
`endif
    end

    // Mid-frame reset at small-raster (13,10), bounded wait.
    hit = 1'b0;
    for (int i = 0; i < 2 * S_FRAME && !hit; i++) begin
      e = model_s(n);
      if (e.x == 10'd13 && e.y == 10'd10) hit = 1'b1;
      else cycle();
    end
    check_eq("wait_13_10", 32'(hit), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("midrst.drawx", 32'(s_x), 32'd0);
    check_eq("midrst.drawy", 32'(s_y), 32'd0);
    check_eq("midrst.hs", 32'(s_hs), 32'd1);
    check_eq("midrst.vs", 32'(s_vs), 32'd1);

    // Random colours with occasional random resets.
    for (int i = 0; i < 4000; i++) begin
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0;
    for (int i = 0; i < S_FRAME + 8; i++) begin
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
